// File: rtl/key_scan4_if.sv
// Keypad/CPU side signals of the 4x4 keypad reader.
interface key_scan4_if;
  logic        KeyCtrl;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keyrdata;
  logic        key_valid;
  logic        key_ovf;
  logic        key_down;

  // master: CPU + keypad matrix; slave: key_scan4
  modport master (output KeyCtrl, col,
                  input  row, keyrdata, key_valid, key_ovf, key_down);
  modport slave  (input  KeyCtrl, col,
                  output row, keyrdata, key_valid, key_ovf, key_down);
endinterface

// File: rtl/key_scan4.sv
// 4x4 matrix keypad reader: row scan, frame-level debounce, 4-digit key buffer.
module key_scan4 #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DB_FRAMES = 4
) (
  input  logic      clk,
  input  logic      rst,
  key_scan4_if.slave bus
);
  localparam int unsigned CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic [3:0]    col_m, col_s;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    row_sel;
  logic          acc_hit;
  logic [3:0]    acc_code;
  logic          row_hit;
  logic [1:0]    row_col;
  logic          frame_close;
  logic          hit;
  logic [3:0]    fcode;
  state_t        state, state_nx;
  logic [3:0]    cand, cand_nx;
  logic [3:0]    n, n_nx;
  logic          accept;
  logic [15:0]   keyrdata_q;
  logic          key_valid_q, key_ovf_q, key_down_q;

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= bus.col;
      col_s <= col_m;
    end
  end

  assign tick        = (cnt == CW'(SCAN_DIV - 1));
  assign frame_close = tick && (row_sel == 2'd3);

  // Row-step divider and row selector
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      row_sel <= '0;
    end else if (tick) begin
      cnt     <= '0;
      row_sel <= row_sel + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bus.row = ~(4'b0001 << row_sel);

  // Lowest pressed column in the currently driven row
  always_comb begin
    row_hit = 1'b0;
    row_col = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col_s[i] && !row_hit) begin
        row_hit = 1'b1;
        row_col = 2'(i);
      end
    end
  end

  // Frame result: an earlier row's key always outranks the current row
  assign hit   = acc_hit | row_hit;
  assign fcode = acc_hit ? acc_code : {row_sel, row_col};

  // Frame accumulator: first key found in the frame, cleared at frame close
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (tick) begin
      if (frame_close) begin
        acc_hit  <= 1'b0;
        acc_code <= '0;
      end else if (!acc_hit && row_hit) begin
        acc_hit  <= 1'b1;
        acc_code <= {row_sel, row_col};
      end
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      n     <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      n     <= n_nx;
    end
  end

  // Debounce next-state, evaluated only at frame close
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    n_nx     = n;
    accept   = 1'b0;
    if (frame_close) begin
      case (state)
        IDLE: begin
          if (hit) begin
            cand_nx = fcode;
            n_nx    = 4'd1;
            if (DB_FRAMES == 1) begin
              accept   = 1'b1;
              state_nx = HELD;
            end else begin
              state_nx = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (hit && fcode == cand) begin
            n_nx = n + 4'd1;
            if (n_nx == 4'(DB_FRAMES)) begin
              accept   = 1'b1;
              state_nx = HELD;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        HELD: begin
          if (!hit) begin
            n_nx     = 4'd1;
            state_nx = (DB_FRAMES == 1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (hit) begin
            state_nx = HELD;
          end else begin
            n_nx = n + 4'd1;
            if (n_nx == 4'(DB_FRAMES)) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Key buffer and status flags; accept outranks a same-edge acknowledge.
  // fcode equals cand whenever accept is raised, and also covers the
  // immediate accept from IDLE where cand is only being loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyrdata_q  <= '0;
      key_valid_q <= 1'b0;
      key_ovf_q   <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      if (accept) begin
        keyrdata_q  <= {keyrdata_q[11:0], fcode};
        key_valid_q <= 1'b1;
      end else if (bus.KeyCtrl) begin
        key_valid_q <= 1'b0;
      end
      if (bus.KeyCtrl)                   key_ovf_q <= 1'b0;
      else if (accept && key_valid_q)    key_ovf_q <= 1'b1;
      key_down_q <= (state_nx == HELD) || (state_nx == RELEASE);
    end
  end

  assign bus.keyrdata  = keyrdata_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_ovf   = key_ovf_q;
  assign bus.key_down  = key_down_q;
endmodule

// File: tb/tb_key_scan4.sv
// Self-checking bench for key_scan4 with a frame-level keypad reference model.
module tb_key_scan4;
  localparam int unsigned SD = 4;
  localparam int unsigned DB = 2;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] pressed;
  logic [3:0]  kcol;

  key_scan4_if bus ();

  key_scan4 #(.SCAN_DIV(SD), .DB_FRAMES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    kcol = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!bus.row[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4 + c]) kcol[c] = 1'b0;
  end
  assign bus.col = kcol;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [15:0] m_buf;
  logic        m_valid, m_ovf, m_down;
  logic [3:0]  m_cand;
  int          m_run, m_rel;

  task automatic model_reset();
    m_buf = '0; m_valid = 0; m_ovf = 0; m_down = 0;
    m_cand = '0; m_run = 0; m_rel = 0;
  endtask

  // One whole frame of key set 'keys', with optional ack on the closing edge
  task automatic model_frame(input logic [15:0] keys, input logic ack);
    bit hit = 0;
    bit acc = 0;
    logic [3:0] code = '0;
    for (int k = 15; k >= 0; k--)
      if (keys[k]) begin hit = 1; code = 4'(k); end
    if (!m_down) begin
      if (m_run == 0) begin
        if (hit) begin m_cand = code; m_run = 1; end
      end else if (hit && code == m_cand) m_run++;
      else m_run = 0;
      if (m_run == DB) begin acc = 1; m_down = 1; m_run = 0; m_rel = 0; end
    end else begin
      if (hit) m_rel = 0; else m_rel++;
      if (m_rel == DB) begin m_down = 0; m_rel = 0; end
    end
    if (acc) begin
      m_buf   = {m_buf[11:0], m_cand};
      m_ovf   = ack ? 1'b0 : (m_ovf | m_valid);
      m_valid = 1'b1;
    end else if (ack) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.KeyCtrl = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input logic [15:0] keys, input logic ack);
    pressed = keys;
    repeat (15) @(posedge clk);
    @(negedge clk);
    bus.KeyCtrl = ack;
    @(posedge clk);
    #1;
    bus.KeyCtrl = 1'b0;
    model_frame(keys, ack);
  endtask

  task automatic test_reset();
    logic [3:0] one = 4'b0001;
    logic [3:0] exp_row;
    pressed = '0;
    do_reset();
    n_total++;
    if ({bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down, bus.row} !== {16'h0, 3'b000, 4'b1110})
      $display("FAIL reset_state: got %h required %h",
               {bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down, bus.row}, {16'h0, 3'b000, 4'b1110});
    else n_pass++;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_row = ~(one << ((k / 4) % 4));
      n_total++;
      if (bus.row !== exp_row)
        $display("FAIL row_walk[%0d]: got %b required %b", k, bus.row, exp_row);
      else n_pass++;
    end
    model_frame('0, 1'b0);
    model_frame('0, 1'b0);
  endtask

  task automatic test_clean_press();
    logic [15:0] k_a = 16'h0400;
    logic [15:0] seq [5] = '{k_a, k_a, k_a, 16'h0, 16'h0};
    for (int f = 0; f < 5; f++) begin
      run_frame(seq[f], 1'b0);
      n_total++;
      if ({bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down} !== {m_buf, m_valid, m_ovf, m_down})
        $display("FAIL press_frame%0d: got %h required %h", f,
                 {bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down}, {m_buf, m_valid, m_ovf, m_down});
      else n_pass++;
      if (f == 0) begin
        n_total++;
        if (bus.key_valid !== 1'b0) $display("FAIL press_early: key_valid got %b required 0", bus.key_valid);
        else n_pass++;
      end
      if (f == 1) begin
        n_total++;
        if ({bus.keyrdata, bus.key_valid, bus.key_down} !== {16'h000A, 2'b11})
          $display("FAIL press_accept: got %h required %h", {bus.keyrdata, bus.key_valid, bus.key_down}, {16'h000A, 2'b11});
        else n_pass++;
      end
    end
    n_total++;
    if (bus.key_down !== 1'b0) $display("FAIL press_release: key_down got %b required 0", bus.key_down);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [15:0] k_a = 16'h0400;
    logic [15:0] seq [5] = '{k_a, 16'h0, k_a, 16'h0, 16'h0};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      run_frame(seq[f], 1'b0);
      n_total++;
      if ({bus.keyrdata, bus.key_valid, bus.key_down} !== {16'h0, 2'b00})
        $display("FAIL bounce_frame%0d: got %h required %h", f, {bus.keyrdata, bus.key_valid, bus.key_down}, {16'h0, 2'b00});
      else n_pass++;
    end
  endtask

  task automatic test_four_keys();
    logic [15:0] one = 16'h0001;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      run_frame(one << k, 1'b0);
      run_frame(one << k, 1'b0);
      run_frame('0, 1'b1);
      run_frame('0, 1'b0);
      n_total++;
      if ({bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down} !== {m_buf, m_valid, m_ovf, m_down})
        $display("FAIL four_keys_k%0d: got %h required %h", k,
                 {bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down}, {m_buf, m_valid, m_ovf, m_down});
      else n_pass++;
    end
    n_total++;
    if ({bus.keyrdata, bus.key_valid, bus.key_ovf} !== {16'h1234, 2'b00})
      $display("FAIL four_keys_final: got %h required %h", {bus.keyrdata, bus.key_valid, bus.key_ovf}, {16'h1234, 2'b00});
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    run_frame(16'h0020, 1'b0);
    run_frame(16'h0020, 1'b0);
    run_frame('0, 1'b0);
    run_frame('0, 1'b0);
    run_frame(16'h0040, 1'b0);
    run_frame(16'h0040, 1'b0);
    n_total++;
    if ({bus.keyrdata, bus.key_valid, bus.key_ovf} !== {16'h0056, 2'b11})
      $display("FAIL overflow_set: got %h required %h", {bus.keyrdata, bus.key_valid, bus.key_ovf}, {16'h0056, 2'b11});
    else n_pass++;
    run_frame('0, 1'b1);
    n_total++;
    if ({bus.keyrdata, bus.key_valid, bus.key_ovf} !== {16'h0056, 2'b00})
      $display("FAIL overflow_ack: got %h required %h", {bus.keyrdata, bus.key_valid, bus.key_ovf}, {16'h0056, 2'b00});
    else n_pass++;
  endtask

  task automatic test_collisions();
    do_reset();
    run_frame(16'h0084, 1'b0);
    run_frame(16'h0084, 1'b0);
    n_total++;
    if ({bus.keyrdata, bus.key_valid} !== {16'h0002, 1'b1})
      $display("FAIL collide_priority: got %h required %h", {bus.keyrdata, bus.key_valid}, {16'h0002, 1'b1});
    else n_pass++;
    run_frame('0, 1'b0);
    run_frame('0, 1'b0);
    run_frame(16'h0200, 1'b0);
    run_frame(16'h0200, 1'b1);
    n_total++;
    if ({bus.keyrdata, bus.key_valid, bus.key_ovf} !== {16'h0029, 2'b10})
      $display("FAIL collide_ack_accept: got %h required %h", {bus.keyrdata, bus.key_valid, bus.key_ovf}, {16'h0029, 2'b10});
    else n_pass++;
  endtask

  task automatic test_rst_confirm();
    do_reset();
    run_frame(16'h0008, 1'b0);
    repeat (7) @(posedge clk);
    do_reset();
    run_frame(16'h0008, 1'b0);
    n_total++;
    if ({bus.keyrdata, bus.key_valid, bus.key_down} !== {16'h0, 2'b00})
      $display("FAIL rst_confirm_noaccept: got %h required %h", {bus.keyrdata, bus.key_valid, bus.key_down}, {16'h0, 2'b00});
    else n_pass++;
    run_frame(16'h0008, 1'b0);
    n_total++;
    if ({bus.keyrdata, bus.key_valid, bus.key_down} !== {16'h0003, 2'b11})
      $display("FAIL rst_confirm_accept: got %h required %h", {bus.keyrdata, bus.key_valid, bus.key_down}, {16'h0003, 2'b11});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] cur = '0;
    logic [15:0] one = 16'h0001;
    logic ack;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       cur = '0;
          3:       cur = 16'($urandom);
          default: cur = one << $urandom_range(0, 15);
        endcase
      end
      ack = ($urandom_range(0, 3) == 0);
      run_frame(cur, ack);
      n_total++;
      if ({bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down} !== {m_buf, m_valid, m_ovf, m_down})
        $display("FAIL random_frame%0d: got %h required %h", i,
                 {bus.keyrdata, bus.key_valid, bus.key_ovf, bus.key_down}, {m_buf, m_valid, m_ovf, m_down});
      else n_pass++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    pressed = '0;
    bus.KeyCtrl = 1'b0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_four_keys();
    test_overflow();
    test_collisions();
    test_rst_confirm();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/key_scan4.md
Name: key_scan4

Overview:
- 4x4 matrix keypad reader. It is the input-side counterpart to the 4-digit seven-segment display driver.
- Drives the keypad rows one at a time, samples the columns, and debounces each press over whole scan frames.
- Each accepted key is shifted into a 16-bit, 4-hex-digit buffer. The CPU reads the buffer through a memory-mapped read port with a read/acknowledge strobe.
- keyrdata format matches the display write data, so software can echo keys straight to the display.

Parameters:
- SCAN_DIV, 50000, clk cycles per row step. Legal values are at least 4.
- DB_FRAMES, 4, consecutive identical frames needed to accept a press, and consecutive empty frames needed to accept a release. Legal range is 1 to 15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- KeyCtrl  input  1  CPU read-acknowledge strobe, one cycle.
- col  input  4  keypad columns, active-low, asynchronous.
- row  output  4  keypad row drive, active-low, one-hot.
- keyrdata  output  16  key buffer; newest key in [3:0], oldest in [15:12].
- key_valid  output  1  an unread key has been accepted.
- key_ovf  output  1  sticky flag: a key was accepted while key_valid was already 1.
- key_down  output  1  a debounced key is currently held.

Behaviour:
- Reset: every register clears on a rst-high clk edge.
  - row_sel=0, so row=4'b1110.
  - keyrdata=0, key_valid=0, key_ovf=0, key_down=0.
  - Scan counter=0, FSM=IDLE, column synchronizer=4'b1111.
  - rst asserted mid-press or mid-debounce aborts everything; after release of rst the block restarts from IDLE at row 0.
- Synchronizer: col passes through 2 flops (col_s) before use.
- Scan timing:
  - cnt counts 0 to SCAN_DIV-1 and wraps; tick = (cnt==SCAN_DIV-1).
  - On tick, sample col_s for the current row_sel, then row_sel <= row_sel+1 (wraps 3 to 0).
  - row = ~(4'b0001 << row_sel).
- Frame evaluation:
  - Within a frame (rows 0 to 3), the first pressed key found wins. Priority: lowest row first, then lowest column index (col[0] first).
  - code = {row_sel[1:0], col_idx[1:0]}, range 0x0 to 0xF.
  - On the tick where row_sel==3, the frame closes with hit and fcode. The frame accumulator then clears.
  - Multiple simultaneous keys: only the priority key counts.
- Debounce FSM, evaluated only at frame close:
  - IDLE:
    - hit: go to CONFIRM, cand=fcode, n=1.
    - If DB_FRAMES==1, accept immediately and go to HELD.
  - CONFIRM:
    - hit and fcode==cand: n=n+1. When n reaches DB_FRAMES, accept cand and go to HELD.
    - Miss, or a different code: go to IDLE with no accept.
  - HELD:
    - No hit: go to RELEASE with n=1. If DB_FRAMES==1, go straight to IDLE instead.
    - Any hit, including a changed code: stay in HELD. There is no auto-repeat.
  - RELEASE:
    - No hit: n=n+1. When n reaches DB_FRAMES, go to IDLE.
    - Hit: go to HELD with no new accept.
- key_down = (state==HELD or state==RELEASE).
- Accept, registered on the frame-close edge:
  - keyrdata <= {keyrdata[11:0], cand}.
  - key_valid <= 1.
  - If key_valid was already 1 and KeyCtrl is not high the same cycle, key_ovf <= 1.
- Read/acknowledge:
  - KeyCtrl high on an edge clears key_valid and key_ovf. keyrdata is not cleared.
  - Accept and KeyCtrl on the same edge: key_valid=1 (accept wins), key_ovf=0.
- Latency: from the first frame closed with the key visible, acceptance takes DB_FRAMES frames. One frame is 4*SCAN_DIV clks.
- keyrdata, key_valid, key_ovf and key_down are all registered outputs.

Test Plan:
All scenarios use SCAN_DIV=4 and DB_FRAMES=2 (1 frame = 16 clk).
- Reset and row walk: rst high for 2 cycles, then release.
  - Outputs are all 0 and row=1110.
  - row then steps 1110, 1101, 1011, 0111 every 4 clk and wraps.
- Clean press: col[2] low whenever row==1011 (key 0x A), held for 3 frames.
  - key_valid rises at the close of the 2nd full frame.
  - keyrdata=16'h000A and key_down=1.
  - Release for 2 frames: key_down=0.
- Bounce reject: key visible for 1 frame, gone the next, then visible 1 frame.
  - No accept; key_valid stays 0 and keyrdata stays 0.
- Four keys 1, 2, 3, 4, each press/release debounced, with KeyCtrl pulsed after each accept.
  - keyrdata=16'h1234, key_ovf=0, and key_valid=0 after the last ack.
- Overflow: accept 0x5, then accept 0x6 without KeyCtrl.
  - key_ovf=1 and keyrdata=16'h0056.
  - A KeyCtrl pulse clears key_valid and key_ovf.
- Collisions:
  - Keys 0x7 and 0x2 held together: 0x2 is accepted (lower row priority).
  - KeyCtrl on the same edge as an accept: key_valid=1 and key_ovf=0.
  - rst mid-CONFIRM: no accept afterwards until a fresh full debounce.
